// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default operand width and small op-decoding helpers.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Bit 1 of the op code selects divide, bit 0 selects unsigned.
    function automatic logic is_div_op(input op_e o);
        return o[1];
    endfunction

    function automatic logic is_signed_op(input op_e o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {partial product, remaining multiplier bits}; shift-add.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits};
//           restoring shift-subtract, quotient bit enters at the LSB.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Single add-or-subtract step; a borrow out of diff means restore.
    always_comb begin
        add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd_i};
        acc_o   = {add_sum, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide unit: FSM, iteration counter,
// operand/accumulator registers and the architectural HI/LO registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busC,
    input  logic [WIDTH-1:0] busB,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two's-complement negate when the flag is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dz_q, dz_d;

    op_e                op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q, neg_rem_q;

    op_e                op_in;
    logic               c_neg, b_neg, div_zero_in;
    logic [WIDTH-1:0]   c_mag, b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand decode: magnitudes and sign flags for the signed ops.
    always_comb begin
        op_in       = op_e'(op);
        c_neg       = is_signed_op(op_in) & busC[WIDTH-1];
        b_neg       = is_signed_op(op_in) & busB[WIDTH-1];
        c_mag       = cond_neg(c_neg, busC);
        b_mag       = cond_neg(b_neg, busB);
        div_zero_in = is_div_op(op_in) && (busB == '0);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_op(op_q)),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_fix = cond_neg2(neg_q, acc_q);
        quo_fix  = cond_neg(neg_q, acc_q[WIDTH-1:0]);
        rem_fix  = cond_neg(neg_rem_q, acc_q[2*WIDTH-1:WIDTH]);
    end

    // Next-state, counter and HI/LO update; cancel overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        if (cancel) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (div_zero_in) begin
                            state_d = S_DONE;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = '0;
                            dz_d    = 1'b0;
                        end
                    end else begin
                        if (hi_we) hi_d = wdata;
                        if (lo_we) lo_d = wdata;
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d = S_DONE;
                    if (is_div_op(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control and architectural state, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // Datapath registers: loaded on accepted start, stepped in CALC.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            op_q      <= op_in;
            opnd_q    <= is_div_op(op_in) ? b_mag : c_mag;
            acc_q     <= {{WIDTH{1'b0}}, (is_div_op(op_in) ? c_mag : b_mag)};
            neg_q     <= c_neg ^ b_neg;
            neg_rem_q <= c_neg;
        end else if (state_q == S_CALC) begin
            acc_q <= step_acc;
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        div_by_zero = (state_q == S_DONE) && dz_q;
        hi          = hi_q;
        lo          = lo_q;
    end

endmodule
